fifo_sync_param: RTL

Parametrised single-clock FIFO and the next-generation storage buffer for the verification testbenches and datapaths.
- Configurable data width and depth; depth need not be a power of two.
- Exact occupancy count, programmable almost-full and almost-empty thresholds, and synchronous flush.
- Per-cycle overflow/underflow pulses plus sticky error flags.
- Active-low read/write strobes for drop-in use alongside existing FIFO benches.

---
 rtl/fifo_sync_pkg.sv | 33 +++
 rtl/fifo_sync_param_if.sv | 42 ++++
 rtl/fifo_sync_mem.sv | 36 +++
 rtl/fifo_sync_sva.sv | 46 ++++
 rtl/fifo_sync_param.sv | 124 ++++++++++++
 5 files changed

// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg
// Shared types and helpers for the parametrised synchronous FIFO.
//   fifo_status_t : status flags as seen by the FIFO user
//   ptr_width()   : width of the wr/rd pointers for a given depth
//   cnt_width()   : width of the occupancy counter (must hold 0..depth)
//   next_ptr()    : wrap-around increment for non power-of-two depths
package fifo_sync_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // A depth of 2 still needs one pointer bit.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // The counter has to represent DEPTH itself, hence depth+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so depths that are not a power of two work.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if
// Bundles the FIFO control, data and status signals.
//   master : the FIFO user (drives strobes, flush, clr_err, data_in)
//   slave  : the FIFO itself (drives data_out, rd_valid, count and flags)
interface fifo_sync_param_if
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic                  flush;
  logic                  clr_err;
  logic                  wr_n;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_sticky;
  logic                  udf_sticky;

  modport master (
    output flush, clr_err, wr_n, data_in, rd_n,
    input  data_out, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow, ovf_sticky, udf_sticky
  );

  modport slave (
    input  flush, clr_err, wr_n, data_in, rd_n,
    output data_out, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow, ovf_sticky, udf_sticky
  );

endinterface

// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem
// DEPTH x DATA_WIDTH register array, one write port, registered read port.
//   clk, rst_n    : clock / async active-low reset (read register only)
//   we,waddr,wdata: write port
//   re,raddr      : read request; rdata updates on the following edge
//   rdata         : registered read data, holds when re is low
module fifo_sync_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // A same-edge write to raddr is not forwarded: the old entry is returned,
  // which is what a simultaneous read+write on a full FIFO needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/fifo_sync_sva.sv
// fifo_sync_sva
// Non-synthesised property checker, bound into every fifo_sync_param.
//   clk, rst_n     : clock / reset of the bound FIFO
//   count          : registered occupancy
//   full, empty    : decoded flags
//   overflow/underflow : rejection pulses
module fifo_sync_sva
  import fifo_sync_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] count,
  input logic             full,
  input logic             empty,
  input logic             overflow,
  input logic             underflow
);

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(count) <= DEPTH);

  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(full && empty));

  // A write can only be rejected because the FIFO was full, a read only
  // because it was empty.
  a_ovf_cause: assert property (@(posedge clk) disable iff (!rst_n)
    overflow |-> $past(full));

  a_udf_cause: assert property (@(posedge clk) disable iff (!rst_n)
    underflow |-> $past(empty));

endmodule

bind fifo_sync_param fifo_sync_sva #(.DEPTH(DEPTH)) u_sva (
  .clk       (clk),
  .rst_n     (rst_n),
  .count     (count_q),
  .full      (status.full),
  .empty     (status.empty),
  .overflow  (overflow_q),
  .underflow (underflow_q)
);

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised single-clock FIFO with exact count, almost-full/empty
// thresholds, synchronous flush, overflow/underflow pulses and sticky flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_sync_param_if.slave (strobes wr_n/rd_n are active-low)
module fifo_sync_param
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_sync_param_if.slave  bus
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_sync_param: DEPTH must be at least 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_sync_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_sync_param: AE_LEVEL must be below DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             rd_valid_q, overflow_q, underflow_q;
  logic             ovf_sticky_q, udf_sticky_q;
  logic             wr_acc, rd_acc, ovf_set, udf_set;
  fifo_status_t     status;

  // Flags decode straight from the registered count, so they never lag it.
  always_comb begin
    status              = '0;
    status.full         = (count_q == FULL_CNT);
    status.empty        = (count_q == '0);
    status.almost_full  = (count_q >= AF_CNT);
    status.almost_empty = (count_q <= AE_CNT);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // A full FIFO still takes a write when a read frees a slot on the same
  // edge; flush masks both strobes so it never produces error pulses.
  assign rd_acc  = !bus.flush && !bus.rd_n && !status.empty;
  assign wr_acc  = !bus.flush && !bus.wr_n && (!status.full || rd_acc);
  assign ovf_set = !bus.flush && !bus.wr_n && !wr_acc;
  assign udf_set = !bus.flush && !bus.rd_n && !rd_acc;

  fifo_sync_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (bus.data_out)
  );

  // Pointers, count, pulses and stickies; flush leaves the stickies alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(next_ptr(int'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(next_ptr(int'(rd_ptr), DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      rd_valid_q  <= rd_acc;
      overflow_q  <= ovf_set;
      underflow_q <= udf_set;
      // A new error wins over a coincident clear.
      if (ovf_set)          ovf_sticky_q <= 1'b1;
      else if (bus.clr_err) ovf_sticky_q <= 1'b0;
      if (udf_set)          udf_sticky_q <= 1'b1;
      else if (bus.clr_err) udf_sticky_q <= 1'b0;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.overflow     = status.overflow;
  assign bus.underflow    = status.underflow;
  assign bus.ovf_sticky   = ovf_sticky_q;
  assign bus.udf_sticky   = udf_sticky_q;

endmodule
